// File: rtl/eth_stats_snapshot_buffer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : eth_stats_snapshot_buffer
// Description : Captures timestamped snapshots of NUM_COUNTERS 64-bit
//               statistics counters whenever a trigger-selected counter
//               changes. Captures are rate limited by min_interval and kept
//               in a DEPTH-entry circular buffer. On overflow the buffer
//               either drops the newest snapshot or overwrites the oldest.
//               The head entry is read one 64-bit word at a time.
// Ports       : clk, rst (async, active high)
//               enable, clear, overwrite, min_interval  - capture control
//               current_time, counters                  - snapshot source
//               rd_valid, rd_pop, rd_index, rd_data     - head-entry read port
//               occupancy, dropped                      - buffer status
// Revision    : 1.0 - initial release
// ============================================================================
module eth_stats_snapshot_buffer #(
    parameter int                      NUM_COUNTERS = 6,
    parameter int                      DEPTH        = 16,
    parameter logic [NUM_COUNTERS-1:0] TRIGGER_MASK = 6'b001001
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable,
    input  logic                         clear,
    input  logic                         overwrite,
    input  logic [31:0]                  min_interval,
    input  logic [63:0]                  current_time,
    input  logic [64*NUM_COUNTERS-1:0]   counters,
    output logic                         rd_valid,
    input  logic                         rd_pop,
    input  logic [3:0]                   rd_index,
    output logic [63:0]                  rd_data,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy,
    output logic [31:0]                  dropped
);

    localparam int              c_AW        = $clog2(DEPTH);
    localparam int              c_OW        = $clog2(DEPTH + 1);
    localparam int              c_NW        = NUM_COUNTERS + 1;
    localparam int              c_WW        = $clog2(c_NW);
    localparam logic [c_OW-1:0] c_DEPTH     = c_OW'(DEPTH);
    localparam logic [3:0]      c_LAST_WORD = 4'(NUM_COUNTERS);
    localparam logic [31:0]     c_MAX32     = 32'hFFFF_FFFF;

    // Word 0 of each entry is the timestamp, word 1+i is counter i.
    logic [63:0]             r_mem [0:DEPTH-1][0:c_NW-1];
    logic [63:0]             r_ref [0:NUM_COUNTERS-1];
    logic [c_AW-1:0]         r_wr_ptr;
    logic [c_AW-1:0]         r_rd_ptr;
    logic [c_OW-1:0]         r_occ;
    logic [31:0]             r_dropped;
    logic [31:0]             r_interval;
    logic                    r_enable_d;

    logic [NUM_COUNTERS-1:0] w_diff;
    logic                    w_change;
    logic                    w_elapsed;
    logic                    w_capture;
    logic                    w_pop;
    logic                    w_full;
    logic                    w_write;
    logic                    w_drop;
    logic                    w_grow;
    logic                    w_advance_rd;
    logic [c_WW-1:0]         w_word;

    for (genvar gi = 0; gi < NUM_COUNTERS; gi++) begin : g_cmp
        assign w_diff[gi] = (counters[64*gi +: 64] != r_ref[gi]);
    end

    // A blocked event is never queued: it simply stays visible here until the
    // interval elapses, so later changes coalesce into a single snapshot and
    // a counter returning to its reference value cancels it.
    assign w_change  = enable && |(w_diff & TRIGGER_MASK);
    assign w_elapsed = (r_interval >= min_interval) || (enable && !r_enable_d);
    assign w_capture = w_change && w_elapsed && !clear;
    assign w_pop     = rd_pop && (r_occ != '0) && !clear;
    assign w_full    = (r_occ == c_DEPTH);

    // A same-cycle pop frees a slot in a full buffer, so nothing is lost.
    assign w_write      = w_capture && (!w_full || w_pop || overwrite);
    assign w_drop       = w_capture && w_full && !w_pop;
    assign w_grow       = w_write && !w_drop;
    assign w_advance_rd = w_pop || (w_drop && overwrite);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_occ      <= '0;
            r_dropped  <= '0;
            r_interval <= '0;
            r_enable_d <= 1'b0;
            for (int i = 0; i < NUM_COUNTERS; i++) begin
                r_ref[i] <= '0;
            end
        end else if (clear) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_occ      <= '0;
            r_dropped  <= '0;
            // Saturated counter makes the interval count as elapsed.
            r_interval <= c_MAX32;
            r_enable_d <= enable;
            for (int i = 0; i < NUM_COUNTERS; i++) begin
                r_ref[i] <= '0;
            end
        end else begin
            r_enable_d <= enable;

            if (w_write) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end
            if (w_advance_rd) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end

            if (w_grow && !w_pop) begin
                r_occ <= r_occ + c_OW'(1);
            end else if (!w_grow && w_pop) begin
                r_occ <= r_occ - c_OW'(1);
            end

            if (w_drop && (r_dropped != c_MAX32)) begin
                r_dropped <= r_dropped + 32'd1;
            end

            // Loading 1 makes the counter equal to cycles since the capture,
            // so min_interval of 0 and 1 both allow back-to-back captures.
            if (w_capture) begin
                r_interval <= 32'd1;
            end else if (r_interval != c_MAX32) begin
                r_interval <= r_interval + 32'd1;
            end

            // References follow every capture, dropped ones included, so a
            // discarded change does not re-trigger.
            if (w_capture) begin
                for (int i = 0; i < NUM_COUNTERS; i++) begin
                    r_ref[i] <= counters[64*i +: 64];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_write) begin
            r_mem[r_wr_ptr][0] <= current_time;
            for (int i = 0; i < NUM_COUNTERS; i++) begin
                r_mem[r_wr_ptr][i+1] <= counters[64*i +: 64];
            end
        end
    end

    assign w_word = rd_index[c_WW-1:0];

    always_comb begin
        rd_data = '0;
        if ((r_occ != '0) && (rd_index <= c_LAST_WORD)) begin
            rd_data = r_mem[r_rd_ptr][w_word];
        end
    end

    assign rd_valid  = (r_occ != '0);
    assign occupancy = r_occ;
    assign dropped   = r_dropped;

endmodule
`default_nettype wire

// File: tb/tb_eth_stats_snapshot_buffer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_eth_stats_snapshot_buffer
// Description : Self-checking bench for eth_stats_snapshot_buffer. A queue
//               based reference model predicts the observable state after
//               every clock edge; a monitor compares it against the DUT.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_eth_stats_snapshot_buffer;

    localparam int         NC    = 6;
    localparam int         DEPTH = 16;
    localparam logic [5:0] MASK  = 6'b001001;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             enable = 1'b0;
    logic             clear = 1'b0;
    logic             overwrite = 1'b0;
    logic [31:0]      min_interval = '0;
    logic [63:0]      current_time = '0;
    logic [64*NC-1:0] counters = '0;
    logic             rd_valid;
    logic             rd_pop = 1'b0;
    logic [3:0]       rd_index = '0;
    logic [63:0]      rd_data;
    logic [4:0]       occupancy;
    logic [31:0]      dropped;

    always #5 clk = ~clk;

    eth_stats_snapshot_buffer #(
        .NUM_COUNTERS (NC),
        .DEPTH        (DEPTH),
        .TRIGGER_MASK (MASK)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .clear        (clear),
        .overwrite    (overwrite),
        .min_interval (min_interval),
        .current_time (current_time),
        .counters     (counters),
        .rd_valid     (rd_valid),
        .rd_pop       (rd_pop),
        .rd_index     (rd_index),
        .rd_data      (rd_data),
        .occupancy    (occupancy),
        .dropped      (dropped)
    );

    typedef logic [64*(NC+1)-1:0] entry_t;
    typedef struct packed {
        logic        valid;
        logic [4:0]  occ;
        logic [31:0] drop;
        logic [63:0] data;
    } exp_t;

    exp_t        exp_q[$];
    entry_t      m_q[$];
    logic [63:0] cnt   [NC];
    logic [63:0] m_ref [NC];
    int unsigned m_drop;
    longint      cyc = 0;
    longint      m_last_cap;
    bit          m_force;
    bit          m_prev_en;
    exp_t        mon_e;

    int n_checks = 0;
    int n_errors = 0;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic [63:0] word_of(entry_t e, int idx);
        if (idx > NC) return '0;
        return e[64*idx +: 64];
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_drop = 0;
        foreach (m_ref[i]) m_ref[i] = '0;
        m_force = 1'b0;
        m_prev_en = 1'b0;
        m_last_cap = cyc;   // interval counter reads 0 on the first live edge
    endtask

    // Drive one cycle of stimulus and push the predicted post-edge state.
    task automatic drive(bit en, bit clr, bit ow, bit pop, logic [31:0] mi, logic [3:0] idx);
        entry_t snap;
        bit     change;
        bit     elapsed;
        exp_t   e;
        @(negedge clk);
        enable       = en;
        clear        = clr;
        overwrite    = ow;
        rd_pop       = pop;
        min_interval = mi;
        rd_index     = idx;
        current_time = 64'h1_0000_0000 + 64'(cyc) * 64'd3;
        for (int i = 0; i < NC; i++) counters[64*i +: 64] = cnt[i];
        snap = {counters, current_time};

        if (clr) begin
            m_q.delete();
            m_drop = 0;
            foreach (m_ref[i]) m_ref[i] = '0;
            m_force = 1'b1;
        end else begin
            change = 1'b0;
            if (en) for (int i = 0; i < NC; i++)
                if (MASK[i] && (cnt[i] != m_ref[i])) change = 1'b1;
            elapsed = m_force || ((cyc - m_last_cap) >= longint'(mi)) || (en && !m_prev_en);
            if (pop && (m_q.size() > 0)) void'(m_q.pop_front());
            if (change && elapsed) begin
                foreach (m_ref[i]) m_ref[i] = cnt[i];
                m_last_cap = cyc;
                m_force = 1'b0;
                if (m_q.size() < DEPTH) begin
                    m_q.push_back(snap);
                end else begin
                    m_drop++;
                    if (ow) begin
                        void'(m_q.pop_front());
                        m_q.push_back(snap);
                    end
                end
            end
        end
        m_prev_en = en;
        cyc++;

        e.valid = (m_q.size() > 0);
        e.occ   = 5'(m_q.size());
        e.drop  = m_drop;
        e.data  = (m_q.size() > 0) ? word_of(m_q[0], int'(idx)) : 64'd0;
        exp_q.push_back(e);
    endtask

    task automatic rand_step();
        for (int i = 0; i < NC; i++)
            if ($urandom_range(0, 3) == 0) cnt[i] = 64'($urandom_range(0, 3));
        drive($urandom_range(0, 9) != 0, $urandom_range(0, 49) == 0,
              $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
              32'($urandom_range(0, 4)), 4'($urandom_range(0, 8)));
    endtask

    task automatic after_edge();
        @(posedge clk);
        #2;
    endtask

    // Monitor: compares every post-edge state against the scoreboard.
    always @(posedge clk) begin
        #1;
        if (!rst && (exp_q.size() > 0)) begin
            mon_e = exp_q.pop_front();
            check("sb_rd_valid",  64'(rd_valid),  64'(mon_e.valid));
            check("sb_occupancy", 64'(occupancy), 64'(mon_e.occ));
            check("sb_dropped",   64'(dropped),   64'(mon_e.drop));
            check("sb_rd_data",   rd_data,        mon_e.data);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        foreach (cnt[i]) cnt[i] = '0;
        #1 rst = 1'b1;
        @(negedge clk);
        check("reset_rd_valid",  64'(rd_valid),  64'd0);
        check("reset_occupancy", 64'(occupancy), 64'd0);
        check("reset_dropped",   64'(dropped),   64'd0);
        check("reset_rd_data",   rd_data,        64'd0);
        @(posedge clk);
        #2 rst = 1'b0;
        model_reset();

        // Basic capture, readback and pop.
        cnt[0] = 64'd100;
        drive(1, 0, 0, 0, 0, 1);
        after_edge();
        check("t1_occupancy", 64'(occupancy), 64'd1);
        check("t1_word1", rd_data, 64'd100);
        drive(1, 0, 0, 1, 0, 0);
        after_edge();
        check("t1_pop_valid", 64'(rd_valid), 64'd0);

        // Untriggered counter changes are ignored.
        cnt[1] = cnt[1] + 64'd5;
        drive(1, 0, 0, 0, 0, 1);
        after_edge();
        check("t2_occupancy", 64'(occupancy), 64'd0);

        // Rate limiting with coalescing.
        drive(1, 1, 0, 0, 10, 0);
        for (int s = 0; s < 15; s++) begin
            if (s == 0 || s == 2 || s == 4) cnt[0] = cnt[0] + 64'd1;
            drive(1, 0, 0, 0, 10, 1);
        end
        after_edge();
        check("t3_occupancy", 64'(occupancy), 64'd2);
        check("t3_head_word1", rd_data, 64'd101);

        // Overflow, drop-newest.
        drive(1, 1, 0, 0, 0, 1);
        for (int k = 1; k <= 20; k++) begin
            cnt[0] = 64'(1000 + k);
            drive(1, 0, 0, 0, 0, 1);
        end
        after_edge();
        check("t4_drop_occupancy", 64'(occupancy), 64'd16);
        check("t4_drop_dropped", 64'(dropped), 64'd4);
        check("t4_drop_head", rd_data, 64'd1001);

        // Overflow, overwrite-oldest.
        drive(1, 1, 1, 0, 0, 1);
        for (int k = 1; k <= 20; k++) begin
            cnt[0] = 64'(2000 + k);
            drive(1, 0, 1, 0, 0, 1);
        end
        after_edge();
        check("t4_ovw_occupancy", 64'(occupancy), 64'd16);
        check("t4_ovw_dropped", 64'(dropped), 64'd4);
        check("t4_ovw_head", rd_data, 64'd2005);

        // Full buffer: capture together with pop.
        cnt[0] = 64'd3000;
        drive(1, 0, 1, 1, 0, 1);
        after_edge();
        check("t5_occupancy", 64'(occupancy), 64'd16);
        check("t5_dropped", 64'(dropped), 64'd4);
        for (int k = 0; k < 15; k++) drive(1, 0, 1, 1, 0, 1);
        after_edge();
        check("t5_tail", rd_data, 64'd3000);

        // Clear wins over a simultaneous change.
        drive(1, 1, 0, 0, 0, 0);
        for (int k = 1; k <= 3; k++) begin
            cnt[0] = 64'(4000 + k);
            drive(1, 0, 0, 0, 0, 0);
        end
        cnt[0] = 64'd5000;
        drive(1, 1, 0, 0, 0, 0);
        after_edge();
        check("t6_clear_occupancy", 64'(occupancy), 64'd0);
        check("t6_clear_dropped", 64'(dropped), 64'd0);

        // Randomised traffic.
        for (int k = 0; k < 400; k++) rand_step();

        // Asynchronous reset in the middle of traffic.
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("midrst_rd_valid",  64'(rd_valid),  64'd0);
        check("midrst_occupancy", 64'(occupancy), 64'd0);
        check("midrst_dropped",   64'(dropped),   64'd0);
        check("midrst_rd_data",   rd_data,        64'd0);
        exp_q.delete();
        @(posedge clk);
        #2 rst = 1'b0;
        model_reset();

        for (int k = 0; k < 100; k++) rand_step();

        repeat (2) @(posedge clk);
        #2;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
